// File: rtl/multicycle_control_if.sv
// Memory request/ready handshake between the control FSM and unified memory.
interface multicycle_control_if;
  logic mem_read;
  logic mem_write;
  logic i_or_d;
  logic mem_ready;

  modport master (
    output mem_read,
    output mem_write,
    output i_or_d,
    input  mem_ready
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  i_or_d,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I main control FSM: sequences fetch, decode, execute,
// memory and write-back over the shared datapath, with bus-timeout halt.
module multicycle_control #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  multicycle_control_if.master mem,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             pc_source,
  output logic             halted,
  output logic [1:0]       cause,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_HALT     = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  localparam logic [1:0] C_NONE    = 2'b00;
  localparam logic [1:0] C_ILLEGAL = 2'b01;
  localparam logic [1:0] C_TIMEOUT = 2'b10;

  localparam logic [7:0] WLIM = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic pcw_c, irw_c, mr_c, mw_c, rw_c;
  logic iord_c, retire;
  logic waiting, expired;
  logic is_mem, is_r, is_i, is_br;

  assign is_mem = (opcode == OP_LOAD) ||
                  (opcode == OP_STORE);
  assign is_r   = (opcode == OP_R);
  assign is_i   = (opcode == OP_I);
  assign is_br  = (opcode == OP_BR) &&
                  (funct3[2:1] == 2'b00);

  assign waiting = ((state_q == S_FETCH) ||
                    (state_q == S_MEM_RD) ||
                    (state_q == S_MEM_WR)) &&
                   !mem.mem_ready;
  assign expired = waiting && (wait_q >= WLIM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cause_q <= C_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    retire     = 1'b0;
    pcw_c      = 1'b0;
    irw_c      = 1'b0;
    mr_c       = 1'b0;
    mw_c       = 1'b0;
    rw_c       = 1'b0;
    iord_c     = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mr_c      = 1'b1;
        alu_src_b = 2'b01;
        if (mem.mem_ready) begin
          irw_c   = 1'b1;
          pcw_c   = 1'b1;
          state_d = S_DECODE;
        end else if (expired) begin
          state_d = S_HALT;
          cause_d = C_TIMEOUT;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        unique case (1'b1)
          is_mem:  state_d = S_MEM_ADDR;
          is_r:    state_d = S_EXEC_R;
          is_i:    state_d = S_EXEC_I;
          is_br:   state_d = S_BRANCH;
          default: begin
            state_d = S_HALT;
            cause_d = C_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = opcode[5] ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mr_c   = 1'b1;
        iord_c = 1'b1;
        if (mem.mem_ready) begin
          state_d = S_MEM_WB;
        end else if (expired) begin
          state_d = S_HALT;
          cause_d = C_TIMEOUT;
        end
      end
      S_MEM_WB: begin
        rw_c       = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mw_c   = 1'b1;
        iord_c = 1'b1;
        if (mem.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (expired) begin
          state_d = S_HALT;
          cause_d = C_TIMEOUT;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        rw_c    = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b01;
        pc_source = 1'b1;
        pcw_c     = ((funct3 == 3'b000) && zero) ||
                    ((funct3 == 3'b001) && !zero);
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
        cause_d = C_ILLEGAL;
      end
    endcase
  end

  // Counter tracks consecutive waits within one state only.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)
      wait_d = '0;
    else if (waiting)
      wait_d = wait_q + 8'd1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (retire)
      cnt_d = cnt_q + CNT_W'(1);
  end

  assign pc_write      = pcw_c & rst_n;
  assign ir_write      = irw_c & rst_n;
  assign mem.mem_read  = mr_c & rst_n;
  assign mem.mem_write = mw_c & rst_n;
  assign reg_write     = rw_c & rst_n;
  assign mem.i_or_d    = iord_c;

  assign halted  = (state_q == S_HALT);
  assign cause   = cause_q;
  assign instret = cnt_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against an instruction-level
// trace model: each instruction expands into its expected cycle sequence.
module tb_multicycle_control;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero;
  logic        pc_write, ir_write, reg_write, mem_to_reg;
  logic [1:0]  alu_src_a, alu_src_b, alu_op;
  logic        pc_source, halted;
  logic [1:0]  cause;
  logic [31:0] instret;
  logic [3:0]  state;

  multicycle_control_if bus ();

  multicycle_control #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct3     (funct3),
    .zero       (zero),
    .mem        (bus.master),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .halted     (halted),
    .cause      (cause),
    .instret    (instret),
    .state      (state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc_no = 0;

  logic        chk_en = 1'b0;
  logic [52:0] exp_vec;
  logic [52:0] act_vec;
  logic        lit_en = 1'b0;
  logic [37:0] lit_vec;
  logic [1:0]  cause_m = 2'b00;
  logic [31:0] inst_m = 32'd0;

  assign act_vec = {state, pc_write, ir_write, bus.i_or_d,
                    bus.mem_read, bus.mem_write, reg_write,
                    mem_to_reg, alu_src_a, alu_src_b, alu_op,
                    pc_source, halted, cause, instret};

  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if (act_vec !== exp_vec) begin
        n_err++;
        $display("FAIL cycle %0d outputs: got %h want %h",
                 cyc_no, act_vec, exp_vec);
      end
    end
    if (lit_en) begin
      n_chk++;
      if ({state, cause, instret} !== lit_vec) begin
        n_err++;
        $display("FAIL literal cycle %0d: got %h want %h",
                 cyc_no, {state, cause, instret}, lit_vec);
      end
    end
  end

  // {pcw, irw, iord, mr, mw, rw, m2r, a, b, op, pcs, halted}
  function automatic logic [14:0] ctl(input int st,
      input logic rdy, input logic z,
      input logic [2:0] f3, input logic rst);
    logic pcw, irw, iord, mr, mw, rw, m2r, pcs, h;
    logic [1:0] a, b, op;
    {pcw, irw, iord, mr, mw, rw, m2r, pcs, h} = '0;
    {a, b, op} = '0;
    case (st)
      0: begin mr = 1; b = 2'b01; pcw = rdy; irw = rdy; end
      1: begin a = 2'b10; b = 2'b10; end
      2: begin a = 2'b01; b = 2'b10; end
      3: begin mr = 1; iord = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mw = 1; iord = 1; end
      6: begin a = 2'b01; op = 2'b10; end
      7: begin a = 2'b01; b = 2'b10; op = 2'b11; end
      8: rw = 1;
      9: begin
        a = 2'b01; op = 2'b01; pcs = 1;
        pcw = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z);
      end
      default: h = 1;
    endcase
    if (!rst) {pcw, irw, mr, mw, rw} = '0;
    return {pcw, irw, iord, mr, mw, rw, m2r, a, b, op, pcs, h};
  endfunction

  task automatic cyc(input int st, input logic rdy);
    bus.mem_ready = rdy;
    exp_vec = {4'(st), ctl(st, rdy, zero, funct3, rst_n),
               cause_m, inst_m};
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    cyc_no++;
    lit_en = 1'b0;
  endtask

  task automatic lit(input int st, input logic [1:0] c,
                     input logic [31:0] n);
    lit_en  = 1'b1;
    lit_vec = {4'(st), c, n};
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic wait_phase(input int st, input int n,
                            output bit to);
    for (int i = 0; i < n && i < TO; i++) cyc(st, 1'b0);
    if (n >= TO) begin
      cause_m = 2'b10;
      to = 1;
    end else begin
      cyc(st, 1'b1);
      to = 0;
    end
  endtask

  task automatic halt_and_reset(input int nh, input bit lh,
      input logic [1:0] lc, input logic [31:0] ln);
    for (int i = 0; i < nh; i++) begin
      if (lh && i == 0) lit(10, lc, ln);
      cyc(10, rnd());
    end
    rst_n = 1'b0;
    cyc(10, rnd());
    rst_n = 1'b1;
    cause_m = 2'b00;
    inst_m = 32'd0;
  endtask

  // kinds: 0 R, 1 I, 2 lw, 3 sw, 4 beq, 5 bne,
  // 6 random illegal opcode, 7 bad branch funct3, 8 opcode 1111111
  task automatic run(input int k, input int fw, input int mw,
      input logic z, input int nh, input bit lh,
      input logic [1:0] lc, input logic [31:0] ln);
    bit to;
    logic [6:0] op;
    zero = z;
    funct3 = 3'($urandom_range(0, 7));
    case (k)
      0: opcode = 7'b0110011;
      1: opcode = 7'b0010011;
      2: opcode = 7'b0000011;
      3: opcode = 7'b0100011;
      4: begin opcode = 7'b1100011; funct3 = 3'd0; end
      5: begin opcode = 7'b1100011; funct3 = 3'd1; end
      6: begin
        do op = 7'($urandom);
        while (op == 7'b0110011 || op == 7'b0010011 ||
               op == 7'b0000011 || op == 7'b0100011 ||
               op == 7'b1100011);
        opcode = op;
      end
      7: begin
        opcode = 7'b1100011;
        funct3 = 3'($urandom_range(2, 7));
      end
      default: opcode = 7'b1111111;
    endcase
    wait_phase(0, fw, to);
    if (to) begin
      halt_and_reset(nh, lh, lc, ln);
      return;
    end
    cyc(1, rnd());
    case (k)
      0: begin cyc(6, rnd()); cyc(8, rnd()); inst_m++; end
      1: begin cyc(7, rnd()); cyc(8, rnd()); inst_m++; end
      2: begin
        cyc(2, rnd());
        wait_phase(3, mw, to);
        if (!to) begin cyc(4, rnd()); inst_m++; end
      end
      3: begin
        cyc(2, rnd());
        wait_phase(5, mw, to);
        if (!to) inst_m++;
      end
      4, 5: begin cyc(9, rnd()); inst_m++; end
      default: begin cause_m = 2'b01; to = 1; end
    endcase
    if (to) halt_and_reset(nh, lh, lc, ln);
  endtask

  function automatic int pick_wait();
    if ($urandom_range(0, 9) == 0)
      return $urandom_range(TO - 2, TO + 1);
    return $urandom_range(0, 3);
  endfunction

  initial begin
    rst_n = 1'b0;
    opcode = 7'd0;
    funct3 = 3'd0;
    zero = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc(0, 1'b1);
    rst_n = 1'b1;

    run(0, 0, 0, 0, 0, 0, 2'd0, 32'd0);
    lit(0, 2'd0, 32'd1);
    run(2, 0, 3, 0, 0, 0, 2'd0, 32'd0);
    lit(0, 2'd0, 32'd2);
    run(4, 0, 0, 1, 0, 0, 2'd0, 32'd0);
    run(4, 0, 0, 0, 0, 0, 2'd0, 32'd0);
    run(5, 0, 0, 0, 0, 0, 2'd0, 32'd0);
    lit(0, 2'd0, 32'd5);
    run(8, 0, 0, 0, 20, 1, 2'd1, 32'd5);
    lit(0, 2'd0, 32'd0);
    run(3, 0, 16, 0, 3, 1, 2'd2, 32'd0);
    run(3, 0, 15, 0, 0, 0, 2'd0, 32'd0);
    lit(0, 2'd0, 32'd1);
    run(3, 2, 0, 0, 0, 0, 2'd0, 32'd0);
    lit(0, 2'd0, 32'd2);

    // reset asserted in the lw write-back cycle
    opcode = 7'b0000011;
    cyc(0, 1'b1);
    cyc(1, 1'b1);
    cyc(2, 1'b1);
    cyc(3, 1'b1);
    rst_n = 1'b0;
    cyc(4, 1'b1);
    rst_n = 1'b1;
    inst_m = 32'd0;
    cause_m = 2'b00;
    lit(0, 2'd0, 32'd0);

    for (int t = 0; t < 250; t++)
      run($urandom_range(0, 7), pick_wait(), pick_wait(),
          rnd(), $urandom_range(1, 5), 0, 2'd0, 32'd0);
    cyc(0, 1'b0);

    chk_en = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
